// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache with single-line refill
module icache_sa #(
  parameter int SETS      = 64,
  parameter int WAYS      = 2,
  parameter int BLK_WORDS = 4
) (
  input  logic                    cpu_clk,
  input  logic                    cpu_rst,
  input  logic                    inst_rreq,
  input  logic [31:0]             inst_addr,
  input  logic                    flush,
  output logic                    inst_valid,
  output logic [31:0]             inst_out,
  input  logic                    mem_rrdy,
  output logic [3:0]              mem_ren,
  output logic [31:0]             mem_raddr,
  input  logic                    mem_rvalid,
  input  logic [BLK_WORDS*32-1:0] mem_rdata,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int WORD_W = $clog2(BLK_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = BLK_WORDS * 32;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FLUSH} state_t;

  state_t state;
  state_t state_nxt;

  // Latched request; byte-offset bits are never needed once the fetch is accepted.
  logic [31:2]       req_addr;
  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              flush_pend;
  logic              unused_addr_bits;

  // Tag/valid/LRU kept in flops; lru_arr[set] names the way to evict next.
  logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
  logic [LINE_W-1:0] data_arr [WAYS][SETS];
  logic [SETS-1:0]   valid_arr [WAYS];
  logic [SETS-1:0]   lru_arr;

  logic              hit;
  logic              hit_way;
  logic [31:0]       hit_word;
  logic              victim;
  logic              victim_found;
  logic              accept;
  logic              lookup_hit;
  logic              lookup_miss;
  logic              fill;

  assign req_word         = req_addr[OFF_W-1:2];
  assign req_idx          = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag          = req_addr[31:OFF_W+IDX_W];
  assign unused_addr_bits = ^inst_addr[1:0];

  assign accept      = (state == IDLE) && !(flush || flush_pend) && inst_rreq;
  assign lookup_hit  = (state == LOOKUP) && hit;
  assign lookup_miss = (state == LOOKUP) && !hit;
  assign fill        = (state == MISS_WAIT) && mem_rvalid;

  function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                            input logic [WORD_W-1:0] sel);
    logic [31:0] word;
    word = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      if (sel == WORD_W'(i)) word = line[i*32 +: 32];
    end
    return word;
  endfunction

  // Tag compare across all ways of the latched set, selecting the hit word.
  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[w][req_idx] && (tag_arr[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_way  = 1'(w);
        hit_word = pick_word(data_arr[w][req_idx], req_word);
      end
    end
  end

  // Victim choice: lowest invalid way first, otherwise the LRU way.
  always_comb begin
    victim_found = 1'b0;
    victim       = (WAYS > 1) ? lru_arr[req_idx] : 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_arr[w][req_idx]) begin
        victim       = 1'(w);
        victim_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and memory read issue; the read is only driven in the handshake cycle.
  always_comb begin
    state_nxt = state;
    mem_ren   = 4'h0;
    mem_raddr = '0;
    case (state)
      IDLE: begin
        if (flush || flush_pend) state_nxt = FLUSH;
        else if (inst_rreq)      state_nxt = LOOKUP;
      end
      LOOKUP: begin
        state_nxt = hit ? IDLE : MISS_REQ;
      end
      MISS_REQ: begin
        if (mem_rrdy) begin
          mem_ren   = 4'hF;
          mem_raddr = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
          state_nxt = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (mem_rvalid) state_nxt = IDLE;
      end
      FLUSH: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, flush bookkeeping, response pulse and saturating counters.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      req_addr   <= '0;
      flush_pend <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      inst_valid <= 1'b0;
      inst_out   <= '0;
      if (accept) req_addr <= inst_addr[31:2];
      if (state == FLUSH)                    flush_pend <= 1'b0;
      else if (flush && (state != IDLE))     flush_pend <= 1'b1;
      if (lookup_hit) begin
        inst_valid <= 1'b1;
        inst_out   <= hit_word;
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end
      if (lookup_miss && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
      if (fill) begin
        inst_valid <= 1'b1;
        inst_out   <= pick_word(mem_rdata, req_word);
      end
    end
  end

  // Valid and LRU maintenance; flush wipes every set in a single cycle.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int w = 0; w < WAYS; w++) valid_arr[w] <= '0;
      lru_arr <= '0;
    end else if (state == FLUSH) begin
      for (int w = 0; w < WAYS; w++) valid_arr[w] <= '0;
      lru_arr <= '0;
    end else if (lookup_hit) begin
      lru_arr[req_idx] <= (WAYS > 1) ? ~hit_way : 1'b0;
    end else if (fill) begin
      for (int w = 0; w < WAYS; w++) begin
        if (victim == 1'(w)) valid_arr[w][req_idx] <= 1'b1;
      end
      lru_arr[req_idx] <= (WAYS > 1) ? ~victim : 1'b0;
    end
  end

  // Tag and line storage written on refill into the victim way.
  always_ff @(posedge cpu_clk) begin
    if (fill) begin
      for (int w = 0; w < WAYS; w++) begin
        if (victim == 1'(w)) begin
          tag_arr[w][req_idx]  <= req_tag;
          data_arr[w][req_idx] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// tb/tb_icache_sa.sv - scoreboard bench for icache_sa
module tb_icache_sa;

  localparam int RVALID_DELAY = 3;

  logic         cpu_clk = 1'b0;
  logic         cpu_rst;
  logic         inst_rreq;
  logic [31:0]  inst_addr;
  logic         flush;
  logic         inst_valid;
  logic [31:0]  inst_out;
  logic         mem_rrdy;
  logic [3:0]   mem_ren;
  logic [31:0]  mem_raddr;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int           checks = 0;
  int           errors = 0;
  int           n_issue = 0;
  logic [31:0]  last_issue = '0;
  logic [31:0]  exp_q[$];

  icache_sa #(.SETS(64), .WAYS(2), .BLK_WORDS(4)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .inst_rreq  (inst_rreq),
    .inst_addr  (inst_addr),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .mem_rrdy   (mem_rrdy),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_word({a[31:4], 4'b0} + 32'(i * 4));
    return l;
  endfunction

  task automatic responder();
    int          cnt = 0;
    logic [31:0] pa = '0;
    forever begin
      @(negedge cpu_clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_line(pa);
        end
      end
      if (mem_ren == 4'hF) begin
        n_issue++;
        last_issue = mem_raddr;
        pa  = mem_raddr;
        cnt = RVALID_DELAY;
      end
    end
  endtask

  task automatic monitor();
    logic [31:0] exp;
    forever begin
      @(negedge cpu_clk); #1;
      if (mem_ren !== 4'h0 && mem_ren !== 4'hF) begin
        checks++; errors++;
        $display("FAIL mem_ren_value got %h want 0 or F", mem_ren);
      end
      if (mem_ren === 4'h0 && mem_raddr !== 32'h0) begin
        checks++; errors++;
        $display("FAIL mem_raddr_idle got %h want 00000000", mem_raddr);
      end
      if (inst_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected inst_valid with inst_out %h, none outstanding", inst_out);
        end else begin
          exp = exp_q.pop_front();
          if (inst_out !== exp) begin
            errors++;
            $display("FAIL sb_inst_out got %h want %h", inst_out, exp);
          end
        end
      end else if (inst_out !== 32'h0) begin
        checks++; errors++;
        $display("FAIL inst_out_idle got %h want 00000000", inst_out);
      end
    end
  endtask

  // lat counts clock edges from the accept edge (inclusive) until inst_valid is seen.
  task automatic fetch(input logic [31:0] addr, output int lat, output int issues,
                       output logic [31:0] iaddr, output bit done);
    int i0;
    repeat (2) @(negedge cpu_clk);
    i0 = n_issue;
    inst_rreq = 1'b1;
    inst_addr = addr;
    exp_q.push_back(mem_word(addr));
    @(posedge cpu_clk);
    lat = 1;
    #1;
    inst_rreq = 1'b0;
    inst_addr = $urandom;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge cpu_clk);
      if (inst_valid === 1'b1) done = 1'b1;
      else begin
        @(posedge cpu_clk);
        lat++;
      end
    end
    issues = n_issue - i0;
    iaddr  = last_issue;
    if (!done) exp_q.delete();
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; inst_rreq = 1'b0; inst_addr = '0; flush = 1'b0;
    mem_rrdy = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge cpu_clk);
    checks++; if (inst_valid !== 1'b0)   begin errors++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
    checks++; if (inst_out !== 32'h0)    begin errors++; $display("FAIL rst_inst_out got %h want 0", inst_out); end
    checks++; if (mem_ren !== 4'h0)      begin errors++; $display("FAIL rst_mem_ren got %h want 0", mem_ren); end
    checks++; if (mem_raddr !== 32'h0)   begin errors++; $display("FAIL rst_mem_raddr got %h want 0", mem_raddr); end
    checks++; if (hit_cnt !== 32'h0)     begin errors++; $display("FAIL rst_hit_cnt got %0d want 0", hit_cnt); end
    checks++; if (miss_cnt !== 32'h0)    begin errors++; $display("FAIL rst_miss_cnt got %0d want 0", miss_cnt); end
    cpu_rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    int lat, iss; logic [31:0] ia; bit done;
    fetch(32'h0000_1004, lat, iss, ia, done);
    checks++; if (!done)                 begin errors++; $display("FAIL cold_done got 0 want 1"); end
    checks++; if (iss != 1)              begin errors++; $display("FAIL cold_issues got %0d want 1", iss); end
    checks++; if (ia !== 32'h0000_1000)  begin errors++; $display("FAIL cold_raddr got %h want 00001000", ia); end
    checks++; if (lat != 3 + RVALID_DELAY) begin errors++; $display("FAIL cold_latency got %0d want %0d", lat, 3 + RVALID_DELAY); end
    checks++; if (miss_cnt !== 32'd1)    begin errors++; $display("FAIL cold_miss_cnt got %0d want 1", miss_cnt); end
  endtask

  task automatic test_hit();
    int lat, iss; logic [31:0] ia; bit done;
    fetch(32'h0000_1008, lat, iss, ia, done);
    checks++; if (!done)              begin errors++; $display("FAIL hit_done got 0 want 1"); end
    checks++; if (lat != 2)           begin errors++; $display("FAIL hit_latency got %0d want 2", lat); end
    checks++; if (iss != 0)           begin errors++; $display("FAIL hit_issues got %0d want 0", iss); end
    checks++; if (hit_cnt !== 32'd1)  begin errors++; $display("FAIL hit_hit_cnt got %0d want 1", hit_cnt); end
    checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL hit_miss_cnt got %0d want 1", miss_cnt); end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [5] = '{32'h2000, 32'h1000, 32'h3000, 32'h1000, 32'h2000};
    int          want  [5] = '{1, 0, 1, 0, 1};
    int lat, iss; logic [31:0] ia; bit done;
    for (int i = 0; i < 5; i++) begin
      fetch(addrs[i], lat, iss, ia, done);
      checks++;
      if (!done || iss != want[i]) begin
        errors++;
        $display("FAIL conflict_step%0d addr %h done %0b issues %0d want issues %0d", i, addrs[i], done, iss, want[i]);
      end
      if (want[i] == 1) begin
        checks++;
        if (ia !== addrs[i]) begin errors++; $display("FAIL conflict_raddr%0d got %h want %h", i, ia, addrs[i]); end
      end
    end
    checks++; if (hit_cnt !== 32'd3)  begin errors++; $display("FAIL conflict_hit_cnt got %0d want 3", hit_cnt); end
    checks++; if (miss_cnt !== 32'd4) begin errors++; $display("FAIL conflict_miss_cnt got %0d want 4", miss_cnt); end
  endtask

  task automatic test_backpressure();
    int lat, iss, bad; logic [31:0] ia; bit done;
    bad = 0;
    mem_rrdy = 1'b0;
    fork
      fetch(32'h0000_4014, lat, iss, ia, done);
      begin
        repeat (2) @(negedge cpu_clk);
        repeat (7) begin
          @(negedge cpu_clk); #1;
          if (mem_ren !== 4'h0) bad++;
        end
        @(negedge cpu_clk);
        mem_rrdy = 1'b1;
      end
    join
    checks++; if (bad != 0)              begin errors++; $display("FAIL bp_ren_stalled got %0d active cycles want 0", bad); end
    checks++; if (!done || iss != 1)     begin errors++; $display("FAIL bp_issues done %0b got %0d want 1", done, iss); end
    checks++; if (ia !== 32'h0000_4010) begin errors++; $display("FAIL bp_raddr got %h want 00004010", ia); end
    checks++; if (miss_cnt !== 32'd5)    begin errors++; $display("FAIL bp_miss_cnt got %0d want 5", miss_cnt); end
  endtask

  task automatic test_flush();
    int lat, iss, i0; logic [31:0] ia; bit done;
    i0 = n_issue;
    fork
      fetch(32'h0000_5024, lat, iss, ia, done);
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge cpu_clk); #1;
          if (n_issue != i0) break;
        end
        @(negedge cpu_clk); flush = 1'b1;
        @(negedge cpu_clk); flush = 1'b0;
      end
    join
    checks++; if (!done || iss != 1) begin errors++; $display("FAIL flush_refill done %0b issues %0d want 1", done, iss); end
    repeat (4) @(negedge cpu_clk);
    checks++; if (hit_cnt !== 32'd3)  begin errors++; $display("FAIL flush_hit_cnt got %0d want 3", hit_cnt); end
    checks++; if (miss_cnt !== 32'd6) begin errors++; $display("FAIL flush_miss_cnt got %0d want 6", miss_cnt); end
    fetch(32'h0000_1008, lat, iss, ia, done);
    checks++; if (!done || iss != 1) begin errors++; $display("FAIL flush_refetch done %0b issues %0d want 1", done, iss); end
    fetch(32'h0000_5024, lat, iss, ia, done);
    checks++; if (!done || iss != 1) begin errors++; $display("FAIL flush_refetch2 done %0b issues %0d want 1", done, iss); end
    fetch(32'h0000_100C, lat, iss, ia, done);
    checks++; if (!done || iss != 0 || lat != 2) begin errors++; $display("FAIL flush_rehit done %0b issues %0d lat %0d want 0 and 2", done, iss, lat); end
  endtask

  task automatic test_reset_mid_refill();
    int lat, iss, i0, seen; logic [31:0] ia; bit done;
    seen = 0;
    repeat (2) @(negedge cpu_clk);
    i0 = n_issue;
    inst_rreq = 1'b1; inst_addr = 32'h0000_6040;
    @(posedge cpu_clk); #1;
    inst_rreq = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge cpu_clk); #1;
      if (n_issue != i0) break;
    end
    checks++; if (n_issue == i0) begin errors++; $display("FAIL rmr_issue got none want 1"); end
    @(negedge cpu_clk); cpu_rst = 1'b1;
    @(negedge cpu_clk); cpu_rst = 1'b0;
    repeat (10) begin
      @(negedge cpu_clk);
      if (inst_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0)          begin errors++; $display("FAIL rmr_inst_valid got %0d pulses want 0", seen); end
    checks++; if (hit_cnt !== 32'd0)  begin errors++; $display("FAIL rmr_hit_cnt got %0d want 0", hit_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL rmr_miss_cnt got %0d want 0", miss_cnt); end
    fetch(32'h0000_6040, lat, iss, ia, done);
    checks++; if (!done || iss != 1)  begin errors++; $display("FAIL rmr_refetch done %0b issues %0d want 1", done, iss); end
    checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL rmr_refetch_miss_cnt got %0d want 1", miss_cnt); end
    fetch(32'h0000_1008, lat, iss, ia, done);
    checks++; if (!done || iss != 1)  begin errors++; $display("FAIL rmr_cleared done %0b issues %0d want 1", done, iss); end
  endtask

  initial begin
    cpu_rst = 1'b1; inst_rreq = 1'b0; inst_addr = '0; flush = 1'b0;
    mem_rrdy = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    fork
      responder();
      monitor();
      begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_flush();
    test_reset_mid_refill();
    repeat (4) @(negedge cpu_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 Parameter SETS, default 64, number of sets; power of two, 2..256.
REQ-002 Parameter WAYS, default 2, associativity; legal values 1 or 2.
REQ-003 Parameter BLK_WORDS, default 4, 32-bit words per line; power of two, 2..8.
REQ-004 Port cpu_clk  input  1  clock; all state rises on posedge.
REQ-005 Port cpu_rst  input  1  reset, asynchronous, active-high.
REQ-006 Port inst_rreq  input  1  fetch request, sampled only in IDLE.
REQ-007 Port inst_addr  input  32  fetch address, word aligned.
REQ-008 Port flush  input  1  invalidate-all request.
REQ-009 Port inst_valid  output  1  one-cycle pulse, inst_out valid.
REQ-010 Port inst_out  output  32  fetched instruction.
REQ-011 Port mem_rrdy  input  1  memory can accept a read.
REQ-012 Port mem_ren  output  4  read enable, 4'hF when issuing.
REQ-013 Port mem_raddr  output  32  line-aligned read address.
REQ-014 Port mem_rvalid  input  1  refill data valid, one-cycle pulse.
REQ-015 Port mem_rdata  input  BLK_WORDS*32  refill line, word 0 in bits [31:0].
REQ-016 Port hit_cnt, miss_cnt  output  32 each  performance counters.

Function
REQ-017 Address split SHALL be: offset = low log2(BLK_WORDS)+2 bits, index = next log2(SETS) bits, tag = remaining upper bits.
REQ-018 Tag, valid and LRU arrays SHALL be flops; data array may be flops or synchronous RAM, provided cycle behaviour below holds.
REQ-019 FSM states SHALL be IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FLUSH.
REQ-020 IDLE: flush=1 -> FLUSH (flush has priority over inst_rreq); else inst_rreq=1 -> latch inst_addr, go LOOKUP; else stay.
REQ-021 LOOKUP: hit = any way with valid set and tag equal; hit -> inst_valid=1 and inst_out=selected word in the next cycle, update LRU to point at the other way, hit_cnt+1, return IDLE.
REQ-022 Hit latency SHALL be exactly 2 cycles from the IDLE accept edge to the inst_valid pulse.
REQ-023 LOOKUP miss -> miss_cnt+1, go MISS_REQ.
REQ-024 MISS_REQ: when mem_rrdy=1, drive mem_ren=4'hF and mem_raddr={latched addr line bits, zero offset} for exactly one cycle, go MISS_WAIT; while mem_rrdy=0 hold mem_ren=0.
REQ-025 MISS_WAIT: on mem_rvalid=1 write the line, tag and valid=1 into the victim way, set LRU to the other way, pulse inst_valid next cycle with the requested word taken from mem_rdata, return IDLE.
REQ-026 Victim SHALL be the first invalid way (way 0 first); if all valid, the LRU way; WAYS=1 always way 0.
REQ-027 FLUSH: clear all valid and LRU bits in one cycle, return IDLE; flush asserted outside IDLE SHALL be recorded as pending and serviced at the next IDLE, before any new request.
REQ-028 mem_ren SHALL be 0 in every cycle except the single issue cycle; mem_raddr SHALL be 0 when mem_ren=0.
REQ-029 inst_valid SHALL never exceed one cycle per accepted request; inst_out SHALL be 0 when inst_valid=0.
REQ-030 Counters SHALL saturate at 32'hFFFFFFFF and are not cleared by flush.
REQ-031 inst_addr changes after acceptance SHALL not affect the in-flight request.

Reset
REQ-032 cpu_rst=1 SHALL asynchronously force state IDLE, all valid/LRU bits 0, flush-pending 0, inst_valid 0, inst_out 0, mem_ren 0, mem_raddr 0, hit_cnt 0, miss_cnt 0.
REQ-033 Reset asserted mid-refill SHALL abandon the refill; a later mem_rvalid SHALL write nothing and produce no inst_valid.

Verification
REQ-034 Cold miss: reset, inst_rreq addr 0x0000_1004, mem_rrdy=1, mem_rvalid 3 cycles after issue with line {W3..W0} -> one mem_ren=4'hF at 0x0000_1000, inst_out=W1, miss_cnt=1.
REQ-035 Hit: repeat 0x0000_1008 -> inst_valid exactly 2 cycles after accept, inst_out=W2, mem_ren stays 0, hit_cnt=1.
REQ-036 Conflict (WAYS=2, SETS=64, BLK_WORDS=4): fill 0x1000, 0x2000 (both index 0), touch 0x1000, fetch 0x3000 -> 0x2000 evicted; refetch 0x1000 hits, 0x2000 misses.
REQ-037 Backpressure: miss with mem_rrdy=0 for 5 cycles -> mem_ren=0 throughout, single issue cycle once mem_rrdy=1.
REQ-038 Flush: assert flush during MISS_WAIT -> refill completes and responds, then FLUSH; refetch 0x1000 misses, counters unchanged by flush.
REQ-039 Reset mid-refill: cpu_rst pulse in MISS_WAIT, then mem_rvalid -> no inst_valid, counters 0, next fetch of same address misses.
